trade_report_packer: RTL and testbench
======================================

// Module: trade_report_packer
// PURPOSE
// - Downstream of the order book engine in the clk_engine domain: captures every trade_valid/trade_info
//   execution report into a word FIFO and packs them into byte-stream report frames for the UDP TX path.
// - Frame = 3-byte opcode, 1-byte trade count, then count x 4-byte trades (big-endian), TLAST on final byte.
// - Frames launch when MAX_TRADES reports are queued, or on idle timeout with at least one queued.
// PARAMETERS
// - DEPTH       16         trade FIFO depth in words; power of 2, >= MAX_TRADES
// - MAX_TRADES  8          max trades per frame (1..255)
// - TIMEOUT     64         cycles a non-empty FIFO may wait in IDLE before a partial frame is forced
// - OPCODE      24'hA0B0C0 frame opcode, sent MSB first
// PORTS
// - clk_engine     in   1                 engine clock; all logic on its rising edge
// - rst_engine     in   1                 synchronous, active-high reset
// - trade_info     in   32                {price[15:0], is_buy, is_bot, qty[13:0]}
// - trade_valid    in   1                 one trade per high cycle
// - m_axis_tdata   out  8                 frame byte
// - m_axis_tvalid  out  1                 byte valid
// - m_axis_tready  in   1                 downstream ready
// - m_axis_tlast   out  1                 last byte of frame
// - fifo_level     out  $clog2(DEPTH)+1   queued trade words
// - drop_count     out  16                trades dropped on overflow; saturates at 16'hFFFF
// - busy           out  1                 high while a frame is in flight (FSM != IDLE)
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, timer 0, FSM IDLE; reset mid-frame abandons the frame (no TLAST
//   emitted) and discards queued trades.
// - Push: trade_valid accepted if level < DEPTH, or level == DEPTH with a pop in the same cycle;
//   otherwise dropped and drop_count +1 (saturating). Push visible in fifo_level next cycle.
// - Pop: occurs when the 4th byte of a trade is accepted (tvalid & tready); simultaneous push+pop leaves
//   level unchanged.
// - Timer: counts in IDLE while level > 0; clears when level == 0 or a frame starts.
// - FSM IDLE -> HDR when level >= MAX_TRADES, or level > 0 and timer == TIMEOUT-1.
//   On entry latch n = min(level, MAX_TRADES); later pushes do not change n.
// - HDR: bytes OPCODE[23:16], OPCODE[15:8], OPCODE[7:0], n[7:0] -> BODY.
// - BODY: per trade, bytes [31:24],[23:16],[15:8],[7:0] of FIFO head; after n trades -> IDLE.
// - Frame length = 4 + 4n bytes. TLAST only on the final BODY byte. Earliest next frame start is the cycle
//   after the final byte is accepted (1-cycle IDLE gap).
// - AXI: outputs registered; tdata/tlast stable while tvalid & !tready; tvalid never drops mid-frame
//   once asserted. First header byte has tvalid high 1 cycle after IDLE->HDR decision.
// - Byte counter is 2 bits (wraps per word); trade counter is 8 bits, compared to n.
// CONFIGURATION
// - TRADE_SEQ_EN defined: 2-byte frame sequence number (MSB first) inserted after the count byte;
//   frame = 6 + 4n bytes; seq = 0 after reset, +1 per completed frame, wraps 16'hFFFF -> 0;
//   not incremented for frames aborted by reset.
// - TRADE_SEQ_EN undefined: no sequence field, no sequence register.
// TESTING
// - 1 trade {105,0,0,10}, tready=1 -> after TIMEOUT cycles 8 bytes: A0 B0 C0 01 00 69 00 0A, TLAST on 0A.
// - 8 trades back-to-back -> frame starts before timeout, count byte 08, 36 bytes, level returns to 0.
// - 20 trades with tready=0 -> fifo_level=16, drop_count=4; release tready -> frames of 8,8 (timeout adds none).
// - tready toggling every cycle mid-frame -> bytes unchanged while stalled, no loss or duplication.
// - Push with level=16 on the cycle a trade pops -> accepted, drop_count unchanged, level stays 16.
// - rst_engine asserted mid-BODY -> next cycle all outputs 0, level 0; a new trade forms a fresh frame
//   (TRADE_SEQ_EN: seq=0; with 65536 frames sent, seq wraps to 0).

Source files
------------

// File: rtl/trade_report_packer.sv
// Packs engine trade execution reports into byte-stream report frames (opcode, count, trades).
// Optional macro TRADE_SEQ_EN inserts a 16-bit frame sequence number after the count byte.
module trade_report_packer #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned MAX_TRADES = 8,
   parameter int unsigned TIMEOUT    = 64,
   parameter logic [23:0] OPCODE     = 24'hA0B0C0
) (
   input  logic                     clk_engine,
   input  logic                     rst_engine,
   input  logic [31:0]              trade_info,
   input  logic                     trade_valid,
   output logic [7:0]               m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [15:0]              drop_count,
   output logic                     busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

`ifdef TRADE_SEQ_EN
   typedef enum logic [1:0] {S_IDLE, S_HDR, S_SEQ, S_BODY} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY} state_t;
`endif

   state_t        state, state_d;
   logic [1:0]    byte_cnt, byte_d;
   logic [7:0]    trade_cnt, trade_d;
   logic [7:0]    n_lat, n_d;
   logic [7:0]    data_d;
   logic          valid_d, last_d;
   logic [TW-1:0] timer;
`ifdef TRADE_SEQ_EN
   logic [15:0]   seq, seq_d;
`endif

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   head;
   logic [7:0]    head_next_msb;
   logic          fire, pop, push_ok, start;

   assign fire          = m_axis_tvalid & m_axis_tready;
   assign pop           = fire & (state == S_BODY) & (byte_cnt == 2'd3);
   assign push_ok       = trade_valid & ((fifo_level < LW'(DEPTH)) | pop);
   assign head          = mem[rd_ptr];
   assign head_next_msb = mem[rd_ptr + AW'(1)][31:24];
   assign busy          = (state != S_IDLE);
   assign start         = (state == S_IDLE) && (fifo_level != '0) &&
                          ((fifo_level >= LW'(MAX_TRADES)) || (timer == TW'(TIMEOUT - 1)));

   // NOTE: the trade storage has no reset; pointers and level alone say which words are valid.
   always_ff @(posedge clk_engine) begin
      if (push_ok) mem[wr_ptr] <= trade_info;
   end

   // NOTE: all sequential state is updated with non-blocking assignments.
   always_ff @(posedge clk_engine) begin
      if (rst_engine) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         drop_count <= '0;
         timer      <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (trade_valid && !push_ok && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
         if (start || fifo_level == '0)
            timer <= '0;
         else if (state == S_IDLE)
            timer <= timer + TW'(1);
      end
   end

   always_ff @(posedge clk_engine) begin
      if (rst_engine) begin
         state         <= S_IDLE;
         byte_cnt      <= '0;
         trade_cnt     <= '0;
         n_lat         <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
`ifdef TRADE_SEQ_EN
         seq           <= '0;
`endif
      end else begin
         state         <= state_d;
         byte_cnt      <= byte_d;
         trade_cnt     <= trade_d;
         n_lat         <= n_d;
         m_axis_tdata  <= data_d;
         m_axis_tvalid <= valid_d;
         m_axis_tlast  <= last_d;
`ifdef TRADE_SEQ_EN
         seq           <= seq_d;
`endif
      end
   end

   // Next-state logic also chooses the byte presented after each accepted one,
   // so the AXI outputs come straight from flops and hold while stalled.
   always_comb begin
      // NOTE: every signal gets its hold value first, so no path can infer a latch.
      state_d = state;
      byte_d  = byte_cnt;
      trade_d = trade_cnt;
      n_d     = n_lat;
      data_d  = m_axis_tdata;
      valid_d = m_axis_tvalid;
      last_d  = m_axis_tlast;
`ifdef TRADE_SEQ_EN
      seq_d   = seq;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               state_d = S_HDR;
               byte_d  = 2'd0;
               trade_d = 8'd0;
               n_d     = (fifo_level >= LW'(MAX_TRADES)) ? 8'(MAX_TRADES) : 8'(fifo_level);
               data_d  = OPCODE[23:16];
               valid_d = 1'b1;
               last_d  = 1'b0;
            end
         end
         S_HDR: begin
            if (fire) begin
               byte_d = byte_cnt + 2'd1;
               case (byte_cnt)
                  2'd0:    data_d = OPCODE[15:8];
                  2'd1:    data_d = OPCODE[7:0];
                  2'd2:    data_d = n_lat;
                  default: begin
`ifdef TRADE_SEQ_EN
                     state_d = S_SEQ;
                     data_d  = seq[15:8];
`else
                     state_d = S_BODY;
                     data_d  = head[31:24];
`endif
                  end
               endcase
            end
         end
`ifdef TRADE_SEQ_EN
         S_SEQ: begin
            if (fire) begin
               if (byte_cnt == 2'd0) begin
                  byte_d = 2'd1;
                  data_d = seq[7:0];
               end else begin
                  state_d = S_BODY;
                  byte_d  = 2'd0;
                  data_d  = head[31:24];
               end
            end
         end
`endif
         S_BODY: begin
            if (fire) begin
               byte_d = byte_cnt + 2'd1;
               case (byte_cnt)
                  2'd0: data_d = head[23:16];
                  2'd1: data_d = head[15:8];
                  2'd2: begin
                     data_d = head[7:0];
                     last_d = (trade_cnt == n_lat - 8'd1);
                  end
                  default: begin
                     trade_d = trade_cnt + 8'd1;
                     if (m_axis_tlast) begin
                        state_d = S_IDLE;
                        data_d  = 8'd0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
`ifdef TRADE_SEQ_EN
                        seq_d   = seq + 16'd1;
`endif
                     end else begin
                        data_d = head_next_msb;
                     end
                  end
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_trade_report_packer.sv
// Self-checking bench for trade_report_packer: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based frame model.
module tb_trade_report_packer;

   localparam int          DEPTH      = 16;
   localparam int          MAX_TRADES = 8;
   localparam int          TIMEOUT    = 64;
   localparam logic [23:0] OPCODE     = 24'hA0B0C0;
`ifdef TRADE_SEQ_EN
   localparam int          HDR_LEN    = 6;
`else
   localparam int          HDR_LEN    = 4;
`endif

   logic        clk_engine = 1'b0;
   logic        rst_engine = 1'b1;
   logic [31:0] trade_info = '0;
   logic        trade_valid = 1'b0;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic [4:0]  fifo_level;
   logic [15:0] drop_count;
   logic        busy;

   trade_report_packer #(
      .DEPTH(DEPTH), .MAX_TRADES(MAX_TRADES), .TIMEOUT(TIMEOUT), .OPCODE(OPCODE)
   ) dut (
      .clk_engine(clk_engine), .rst_engine(rst_engine),
      .trade_info(trade_info), .trade_valid(trade_valid),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .fifo_level(fifo_level), .drop_count(drop_count), .busy(busy)
   );

   always #5 clk_engine = ~clk_engine;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: queued trades, the frame in flight as a byte list, and the idle wait count.
   logic [31:0] mq[$];
   logic [7:0]  m_frame[$];
   logic [7:0]  rx[$];
   bit          m_busy = 0;
   bit          mon_on = 0;
   int          m_idx = 0;
   int          m_wait = 0;
   int          m_drops = 0;
   int          m_seq = 0;
   int          frames_seen = 0;
   int          cyc = 0;
   int          push_cyc = 0;
   int          start_cyc = 0;

   always @(negedge clk_engine) begin
      bit          fire, pop, start, acc;
      int          n;
      logic [31:0] w;
      cyc++;
      if (mon_on) begin
         check("busy", busy, m_busy);
         check("level", fifo_level, mq.size());
         check("drops", drop_count, m_drops);
         check("tvalid", m_axis_tvalid, m_busy);
         if (m_busy) begin
            check("tdata", m_axis_tdata, m_frame[m_idx]);
            check("tlast", m_axis_tlast, m_idx == m_frame.size() - 1);
         end else begin
            check("tlast_idle", m_axis_tlast, 0);
         end
      end
      if (rst_engine) begin
         mq.delete();
         m_busy = 0; m_idx = 0; m_wait = 0; m_drops = 0; m_seq = 0;
      end else begin
         fire  = m_busy && m_axis_tready;
         pop   = fire && m_idx >= HDR_LEN && ((m_idx - HDR_LEN) % 4) == 3;
         start = !m_busy && mq.size() > 0 &&
                 (mq.size() >= MAX_TRADES || m_wait == TIMEOUT - 1);
         if (trade_valid) push_cyc = cyc;
         if (fire) begin
            rx.push_back(m_axis_tdata);
            if (m_axis_tlast) frames_seen++;
         end
         if (start || mq.size() == 0) m_wait = 0;
         else if (!m_busy) m_wait++;
         if (start) begin
            n = (mq.size() < MAX_TRADES) ? mq.size() : MAX_TRADES;
            m_frame.delete();
            m_frame.push_back(OPCODE[23:16]);
            m_frame.push_back(OPCODE[15:8]);
            m_frame.push_back(OPCODE[7:0]);
            m_frame.push_back(8'(n));
`ifdef TRADE_SEQ_EN
            m_frame.push_back(8'(m_seq >> 8));
            m_frame.push_back(8'(m_seq));
`endif
            for (int i = 0; i < n; i++) begin
               w = mq[i];
               m_frame.push_back(w[31:24]);
               m_frame.push_back(w[23:16]);
               m_frame.push_back(w[15:8]);
               m_frame.push_back(w[7:0]);
            end
            m_busy = 1; m_idx = 0; start_cyc = cyc + 1;
         end else if (fire) begin
            if (m_idx == m_frame.size() - 1) begin
               m_busy = 0;
               m_seq  = (m_seq + 1) % 65536;
            end else begin
               m_idx++;
            end
         end
         acc = trade_valid && (mq.size() < DEPTH || pop);
         if (trade_valid && !acc && m_drops < 65535) m_drops++;
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back(trade_info);
      end
   end

   task automatic tick();
      @(posedge clk_engine);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      trade_valid = 1'b1;
      trade_info  = w;
      tick();
      trade_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      bit done = 0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (!m_busy && mq.size() == 0) begin
            done = 1;
            break;
         end
         tick();
      end
      check(tag, done, 1);
   endtask

   initial begin
      logic [7:0]  exp_b[$];
      logic [31:0] words[8];
      logic [31:0] w;
      int          f0, d0;
      bit          hit;

      repeat (3) tick();
      mon_on = 1;
      rst_engine = 1'b0;
      check("reset_tvalid", m_axis_tvalid, 0);
      check("reset_tdata", m_axis_tdata, 0);
      check("reset_level", fifo_level, 0);
      tick();

      // Single trade: forced out by the idle timeout.
      m_axis_tready = 1'b1;
      rx.delete();
      f0 = frames_seen;
      push({16'd105, 1'b0, 1'b0, 14'd10});
      wait_drain("t1_drain", 300);
      exp_b = '{8'hA0, 8'hB0, 8'hC0, 8'h01};
`ifdef TRADE_SEQ_EN
      exp_b.push_back(8'h00);
      exp_b.push_back(8'h00);
`endif
      exp_b.push_back(8'h00); exp_b.push_back(8'h69);
      exp_b.push_back(8'h00); exp_b.push_back(8'h0A);
      check("t1_len", rx.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < rx.size(); i++) check("t1_byte", rx[i], exp_b[i]);
      check("t1_latency", start_cyc - push_cyc, TIMEOUT + 1);
      check("t1_frames", frames_seen - f0, 1);
      tick();

      // Eight back-to-back trades launch a full frame well before the timeout.
      rx.delete();
      f0 = frames_seen;
      for (int i = 0; i < 8; i++) push($urandom);
      check("t2_early", (start_cyc - push_cyc) < TIMEOUT, 1);
      wait_drain("t2_drain", 200);
      check("t2_len", rx.size(), HDR_LEN + 32);
      if (rx.size() > 3) check("t2_count", rx[3], 8);
      check("t2_frames", frames_seen - f0, 1);
      check("t2_level", fifo_level, 0);
      tick();

      // Overflow while the sink is stalled, then two full frames on release.
      m_axis_tready = 1'b0;
      d0 = m_drops;
      for (int i = 0; i < 20; i++) push($urandom);
      tick();
      check("t3_level", fifo_level, DEPTH);
      check("t3_drops", drop_count, d0 + 4);
      rx.delete();
      f0 = frames_seen;
      wait_drain("t3_drain", 300);
      check("t3_len", rx.size(), 2 * (HDR_LEN + 32));
      if (rx.size() > HDR_LEN + 35) begin
         check("t3_count0", rx[3], 8);
         check("t3_count1", rx[HDR_LEN + 35], 8);
      end
      check("t3_frames", frames_seen - f0, 2);
      tick();

      // Ready toggling every cycle mid-frame.
      m_axis_tready = 1'b0;
      rx.delete();
      for (int i = 0; i < 8; i++) begin
         words[i] = $urandom;
         push(words[i]);
      end
      for (int i = 0; i < 120; i++) begin
         m_axis_tready = ~m_axis_tready;
         tick();
      end
      wait_drain("t4_drain", 200);
      check("t4_len", rx.size(), HDR_LEN + 32);
      for (int i = 0; i < 8 && rx.size() >= HDR_LEN + 32; i++) begin
         w = {rx[HDR_LEN + 4*i], rx[HDR_LEN + 4*i + 1], rx[HDR_LEN + 4*i + 2], rx[HDR_LEN + 4*i + 3]};
         check("t4_word", w, words[i]);
      end
      tick();

      // Push into a full FIFO on the very cycle a trade pops.
      m_axis_tready = 1'b0;
      for (int i = 0; i < 16; i++) push($urandom);
      tick();
      check("t5_full", fifo_level, DEPTH);
      d0 = m_drops;
      m_axis_tready = 1'b1;
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if (m_busy && m_idx >= HDR_LEN && ((m_idx - HDR_LEN) % 4) == 3) begin
            hit = 1;
            push($urandom);
         end else begin
            tick();
         end
      end
      check("t5_hit", hit, 1);
      check("t5_level", fifo_level, DEPTH);
      check("t5_drops", drop_count, d0);
      wait_drain("t5_drain", 400);
      tick();

      // Reset in the middle of the body abandons the frame and queue.
      for (int i = 0; i < 8; i++) push($urandom);
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if (m_busy && m_idx >= HDR_LEN + 2) hit = 1;
         else tick();
      end
      check("t6_reach", hit, 1);
      f0 = frames_seen;
      rst_engine = 1'b1;
      tick();
      rst_engine = 1'b0;
      check("t6_tvalid", m_axis_tvalid, 0);
      check("t6_tdata", m_axis_tdata, 0);
      check("t6_tlast", m_axis_tlast, 0);
      check("t6_level", fifo_level, 0);
      check("t6_drops", drop_count, 0);
      check("t6_busy", busy, 0);
      check("t6_no_last", frames_seen - f0, 0);
      tick();
      rx.delete();
      push(32'h1234_5678);
      wait_drain("t6_drain", 300);
      check("t6_len", rx.size(), HDR_LEN + 4);
      if (rx.size() == HDR_LEN + 4) begin
         check("t6_count", rx[3], 1);
`ifdef TRADE_SEQ_EN
         check("t6_seq_hi", rx[4], 0);
         check("t6_seq_lo", rx[5], 0);
`endif
         check("t6_word", {rx[HDR_LEN], rx[HDR_LEN+1], rx[HDR_LEN+2], rx[HDR_LEN+3]}, 32'h1234_5678);
      end
      tick();

      // Random traffic with varying load and back-pressure.
      for (int blk = 0; blk < 8; blk++) begin
         int p_push, p_ready;
         p_push  = $urandom_range(2, 60);
         p_ready = $urandom_range(20, 100);
         for (int i = 0; i < 500; i++) begin
            trade_valid   = ($urandom_range(0, 99) < p_push);
            trade_info    = $urandom;
            m_axis_tready = ($urandom_range(0, 99) < p_ready);
            tick();
         end
      end
      trade_valid = 1'b0;
      wait_drain("rand_drain", 2000);
      check("final_level", fifo_level, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
